pipe_hazard_ctrl: RTL and testbench

- Central sequencing/hazard controller for the 5-stage pipeline.
- Drives the IF/ID register controls (enable, stall, flush), PC write enable and the ID/EX bubble.
- Freezes the whole pipeline on multi-cycle data-memory accesses.
- Runs a post-reset boot sequence, a memory-timeout halt, and a stall-cycle counter for debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing / hazard controller:
// controller state encoding, register-field width, NOP encoding and
// the register-match helper used by hazard detection.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } ctrl_state_t;

    localparam int          REG_ADDR_W = 5;

    // Instruction word written into IF/ID when IFFlush_o is asserted.
    localparam logic [31:0] NOP_INSTR  = 32'b0;

    // A producer register matches a consumer register only when it is not r0,
    // because r0 is hard-wired and can never carry a dependency.
    function automatic logic reg_match(input logic [REG_ADDR_W-1:0] dst,
                                       input logic [REG_ADDR_W-1:0] src);
        return (dst != {REG_ADDR_W{1'b0}}) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller. The pipeline
// side (master) supplies decode/memory status, the controller side
// (slave) returns the register enables, stalls and flushes.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_ADDR_W-1:0] IFID_Rs_i;
    logic [REG_ADDR_W-1:0] IFID_Rt_i;
    logic                  IDEX_MemRead_i;
    logic [REG_ADDR_W-1:0] IDEX_Rt_i;
    logic                  branch_taken_i;
    logic                  jump_i;
    logic                  dmem_req_i;
    logic                  dmem_ack_i;

    logic                  PCWrite_o;
    logic                  IFID_i_o;
    logic                  IFID_stall_o;
    logic                  IFFlush_o;
    logic                  IDEX_bubble_o;
    logic                  freeze_o;
    logic                  halt_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output IFID_Rs_i, IFID_Rt_i, IDEX_MemRead_i, IDEX_Rt_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        input  PCWrite_o, IFID_i_o, IFID_stall_o, IFFlush_o,
               IDEX_bubble_o, freeze_o, halt_o, stall_cnt_o
    );

    modport slave (
        input  IFID_Rs_i, IFID_Rt_i, IDEX_MemRead_i, IDEX_Rt_i,
               branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        output PCWrite_o, IFID_i_o, IFID_stall_o, IFFlush_o,
               IDEX_bubble_o, freeze_o, halt_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection: the instruction in ID needs a register that
// a load currently in EX has not yet produced.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rt,
    output logic                  load_use
);

    assign load_use = idex_mem_read &&
                      (reg_match(idex_rt, ifid_rs) || reg_match(idex_rt, ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing / hazard controller for the 5-stage pipeline:
// post-reset boot window, load-use stall, branch/jump flush, whole-pipe
// freeze during multi-cycle memory accesses, timeout halt and a
// saturating stall-cycle counter for debug.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
)(
    input  logic              clk_i,
    input  logic              start_i,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0]       TO_LIMIT  = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    ctrl_state_t      state_r;
    ctrl_state_t      state_nxt_s;
    logic [3:0]       boot_cnt_r;
    logic [3:0]       boot_cnt_nxt_s;
    logic [7:0]       to_cnt_r;
    logic [7:0]       to_cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] stall_cnt_nxt_s;

    logic lu_s;
    logic mw_s;
    logic redirect_s;

    logic run_pc_write_s;
    logic run_stall_s;
    logic run_flush_s;
    logic run_bubble_s;

    logic pc_write_s;
    logic ifid_en_s;
    logic ifid_stall_s;
    logic if_flush_s;
    logic bubble_s;
    logic freeze_s;
    logic halt_s;

    hazard_detect u_hazard_detect (
        .ifid_rs       (bus.IFID_Rs_i),
        .ifid_rt       (bus.IFID_Rt_i),
        .idex_mem_read (bus.IDEX_MemRead_i),
        .idex_rt       (bus.IDEX_Rt_i),
        .load_use      (lu_s)
    );

    assign mw_s       = bus.dmem_req_i && !bus.dmem_ack_i;
    assign redirect_s = bus.branch_taken_i || bus.jump_i;

    // Normal-flow controls: load-use stall wins over a redirect, which is
    // simply re-evaluated once the stall clears.
    always_comb begin
        run_pc_write_s = 1'b1;
        run_stall_s    = 1'b0;
        run_flush_s    = 1'b0;
        run_bubble_s   = 1'b0;
        if (lu_s) begin
            run_pc_write_s = 1'b0;
            run_stall_s    = 1'b1;
            run_bubble_s   = 1'b1;
        end else if (redirect_s) begin
            run_flush_s    = 1'b1;
        end else begin
            run_pc_write_s = 1'b1;
        end
    end

    // Next-state, counter updates and pipeline control outputs.
    always_comb begin
        state_nxt_s    = state_r;
        boot_cnt_nxt_s = boot_cnt_r;
        to_cnt_nxt_s   = to_cnt_r;
        pc_write_s     = 1'b0;
        ifid_en_s      = 1'b0;
        ifid_stall_s   = 1'b1;
        if_flush_s     = 1'b0;
        bubble_s       = 1'b0;
        freeze_s       = 1'b0;
        halt_s         = 1'b0;
        case (state_r)
            BOOT: begin
                bubble_s = 1'b1;
                if (boot_cnt_r == BOOT_LAST) begin
                    state_nxt_s    = RUN;
                    boot_cnt_nxt_s = 4'd0;
                end else begin
                    boot_cnt_nxt_s = boot_cnt_r + 4'd1;
                end
            end
            RUN: begin
                ifid_en_s = 1'b1;
                if (mw_s) begin
                    freeze_s     = 1'b1;
                    state_nxt_s  = MEMWAIT;
                    to_cnt_nxt_s = 8'd1;
                end else begin
                    pc_write_s   = run_pc_write_s;
                    ifid_stall_s = run_stall_s;
                    if_flush_s   = run_flush_s;
                    bubble_s     = run_bubble_s;
                end
            end
            MEMWAIT: begin
                ifid_en_s = 1'b1;
                if (bus.dmem_ack_i) begin
                    // Ack cycle releases the freeze; a request arriving now is
                    // picked up by RUN on the following cycle.
                    pc_write_s   = run_pc_write_s;
                    ifid_stall_s = run_stall_s;
                    if_flush_s   = run_flush_s;
                    bubble_s     = run_bubble_s;
                    state_nxt_s  = RUN;
                end else begin
                    freeze_s = 1'b1;
                    if (to_cnt_r == TO_LIMIT) begin
                        state_nxt_s = HALT;
                    end else begin
                        to_cnt_nxt_s = to_cnt_r + 8'd1;
                    end
                end
            end
            HALT: begin
                ifid_en_s = 1'b1;
                freeze_s  = 1'b1;
                halt_s    = 1'b1;
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // Stall counter advances on every stalled cycle outside the boot window
    // and sticks at all-ones.
    always_comb begin
        if ((state_r != BOOT) && ifid_stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_nxt_s = stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // State and counter registers; start_i low restarts the boot sequence.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_r     <= BOOT;
            boot_cnt_r  <= 4'd0;
            to_cnt_r    <= 8'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            boot_cnt_r  <= boot_cnt_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign bus.PCWrite_o     = pc_write_s;
    assign bus.IFID_i_o      = ifid_en_s;
    assign bus.IFID_stall_o  = ifid_stall_s;
    assign bus.IFFlush_o     = if_flush_s;
    assign bus.IDEX_bubble_o = bubble_s;
    assign bus.freeze_o      = freeze_s;
    assign bus.halt_o        = halt_s;
    assign bus.stall_cnt_o   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all checked
// against a cycle-level behavioural model of the controller rules.
module tb_pipe_hazard_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk_i   = 1'b0;
    logic start_i = 1'b1;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i   (clk_i),
        .start_i (start_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       mr;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       jmp;
        logic       req;
        logic       ack;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  pc;
        logic  stall;
        logic  flush;
        logic  bub;
        logic  frz;
    } vec_t;

    typedef struct {
        logic             pc;
        logic             ifid_en;
        logic             stall;
        logic             flush;
        logic             bub;
        logic             frz;
        logic             halt;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    typedef struct {
        logic             pc;
        logic             ifid_en;
        logic             stall;
        logic             flush;
        logic             bub;
        logic             frz;
        logic             halt;
        logic [CNT_W-1:0] cnt;
        bit               en_known;
        bit               fb_known;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: cycles of boot left, memory-wait bookkeeping,
    // halt flag and the saturating stall count.
    int m_boot_left;
    int m_wait_n;
    int m_stalls;
    bit m_waiting;
    bit m_halted;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic mr, input logic [4:0] idr, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic br, input logic jmp,
                                 input logic req, input logic ack);
        stim_t s;
        s.mr = mr; s.idex_rt = idr; s.rs = rs; s.rt = rt;
        s.br = br; s.jmp = jmp; s.req = req; s.ack = ack;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.IDEX_MemRead_i = s.mr;
        bus.IDEX_Rt_i      = s.idex_rt;
        bus.IFID_Rs_i      = s.rs;
        bus.IFID_Rt_i      = s.rt;
        bus.branch_taken_i = s.br;
        bus.jump_i         = s.jmp;
        bus.dmem_req_i     = s.req;
        bus.dmem_ack_i     = s.ack;
    endtask

    task automatic model_reset();
        m_boot_left = BOOT_CYCLES;
        m_wait_n    = 0;
        m_stalls    = 0;
        m_waiting   = 1'b0;
        m_halted    = 1'b0;
    endtask

    // Expected outputs for this cycle from the controller rules, then the
    // model advances to the next cycle.
    task automatic model_eval(input stim_t s, output exp_t e);
        bit lu;
        bit mw;
        bit in_boot;
        lu = s.mr && (s.idex_rt != 5'd0) && ((s.idex_rt == s.rs) || (s.idex_rt == s.rt));
        mw = s.req && !s.ack;
        in_boot = 1'b0;
        e.pc = 1'b0; e.ifid_en = 1'b0; e.stall = 1'b0; e.flush = 1'b0;
        e.bub = 1'b0; e.frz = 1'b0; e.halt = 1'b0;
        e.cnt = CNT_W'(m_stalls);
        e.en_known = 1'b1;
        e.fb_known = 1'b1;
        if (m_halted) begin
            e.frz = 1'b1; e.stall = 1'b1; e.halt = 1'b1;
            e.en_known = 1'b0; e.fb_known = 1'b0;
        end else if (m_boot_left > 0) begin
            in_boot = 1'b1;
            e.stall = 1'b1; e.bub = 1'b1;
            m_boot_left--;
        end else if (m_waiting && !s.ack) begin
            e.frz = 1'b1; e.stall = 1'b1; e.en_known = 1'b0;
            m_wait_n++;
            if (m_wait_n >= MEM_TIMEOUT) m_halted = 1'b1;
        end else if (!m_waiting && mw) begin
            e.frz = 1'b1; e.stall = 1'b1; e.ifid_en = 1'b1;
            m_waiting = 1'b1;
            m_wait_n  = 0;
        end else begin
            m_waiting = 1'b0;
            e.ifid_en = 1'b1;
            if (lu) begin
                e.stall = 1'b1; e.bub = 1'b1;
            end else begin
                e.pc = 1'b1; e.flush = s.br || s.jmp;
            end
        end
        if (!in_boot && e.stall && (m_stalls < CNT_MAX)) m_stalls++;
    endtask

    // One clock cycle: drive after the edge, sample and check mid-cycle.
    task automatic step(input stim_t s, output obs_t o);
        exp_t e;
        drive(s);
        @(negedge clk_i);
        o.pc = bus.PCWrite_o; o.ifid_en = bus.IFID_i_o; o.stall = bus.IFID_stall_o;
        o.flush = bus.IFFlush_o; o.bub = bus.IDEX_bubble_o; o.frz = bus.freeze_o;
        o.halt = bus.halt_o; o.cnt = bus.stall_cnt_o;
        model_eval(s, e);
        chk1("model_PCWrite", o.pc, e.pc);
        chk1("model_IFID_stall", o.stall, e.stall);
        chk1("model_freeze", o.frz, e.frz);
        chk1("model_halt", o.halt, e.halt);
        chkn("model_stall_cnt", o.cnt, e.cnt);
        if (e.en_known) chk1("model_IFID_i", o.ifid_en, e.ifid_en);
        if (e.fb_known) begin
            chk1("model_IFFlush", o.flush, e.flush);
            chk1("model_IDEX_bubble", o.bub, e.bub);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int n);
        start_i = 1'b0;
        #1;
        chk1("rst_PCWrite", bus.PCWrite_o, 1'b0);
        chk1("rst_IFID_i", bus.IFID_i_o, 1'b0);
        chk1("rst_IDEX_bubble", bus.IDEX_bubble_o, 1'b1);
        chk1("rst_freeze", bus.freeze_o, 1'b0);
        chk1("rst_halt", bus.halt_o, 1'b0);
        chkn("rst_stall_cnt", bus.stall_cnt_o, CNT_W'(0));
        repeat (n) @(posedge clk_i);
        #1;
        start_i = 1'b1;
        model_reset();
    endtask

    vec_t  tbl[12];
    stim_t s_idle;
    stim_t s_lu;
    stim_t s_req;
    stim_t s_ack;
    obs_t  o;

    initial begin
        s_idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_lu   = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_req  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        s_ack  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        //                mr    idex_rt rs     rt     br    jmp   req   ack      pc    stall flush bub   frz
        tbl[0]  = '{mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{mk(1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{mk(1'b1, 5'd7,  5'd3,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{mk(1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{mk(1'b0, 5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{mk(1'b1, 5'd9,  5'd9,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{mk(1'b0, 5'd9,  5'd9,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{mk(1'b1, 5'd12, 5'd4,  5'd12, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{mk(1'b1, 5'd6,  5'd5,  5'd4,  1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{mk(1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        drive(s_idle);
        model_reset();
        #2;

        // Reset held 3 cycles, then a 2-cycle boot window before RUN.
        do_reset(3);
        step(s_idle, o);
        chk1("boot1_IFID_i", o.ifid_en, 1'b0);
        chk1("boot1_PCWrite", o.pc, 1'b0);
        step(s_idle, o);
        chk1("boot2_IFID_i", o.ifid_en, 1'b0);
        chk1("boot2_PCWrite", o.pc, 1'b0);
        step(s_idle, o);
        chk1("run_PCWrite", o.pc, 1'b1);
        chk1("run_IFID_i", o.ifid_en, 1'b1);
        chkn("run_stall_cnt", o.cnt, CNT_W'(0));

        // Directed single-cycle vectors in RUN.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, o);
            chk1($sformatf("tbl%0d_PCWrite", i), o.pc, tbl[i].pc);
            chk1($sformatf("tbl%0d_IFID_stall", i), o.stall, tbl[i].stall);
            chk1($sformatf("tbl%0d_IFFlush", i), o.flush, tbl[i].flush);
            chk1($sformatf("tbl%0d_IDEX_bubble", i), o.bub, tbl[i].bub);
            chk1($sformatf("tbl%0d_freeze", i), o.frz, tbl[i].frz);
            chk1($sformatf("tbl%0d_IFID_i", i), o.ifid_en, 1'b1);
        end

        // Memory access acked on the 4th cycle: 3 frozen cycles.
        do_reset(1);
        step(s_idle, o);
        step(s_idle, o);
        for (int i = 0; i < 3; i++) begin
            step(s_req, o);
            chk1($sformatf("mem_freeze%0d", i), o.frz, 1'b1);
            chk1($sformatf("mem_PCWrite%0d", i), o.pc, 1'b0);
        end
        step(s_ack, o);
        chk1("mem_ack_freeze", o.frz, 1'b0);
        chk1("mem_ack_PCWrite", o.pc, 1'b1);
        step(s_idle, o);
        chkn("mem_stall_cnt", o.cnt, CNT_W'(3));

        // Memory timeout: HALT after the 4th unacked MEMWAIT cycle, sticky.
        do_reset(1);
        step(s_idle, o);
        step(s_idle, o);
        step(s_req, o);
        chk1("to_first_freeze", o.frz, 1'b1);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step(s_req, o);
            chk1($sformatf("to_wait%0d_halt", i), o.halt, 1'b0);
            chk1($sformatf("to_wait%0d_freeze", i), o.frz, 1'b1);
        end
        step(s_req, o);
        chk1("to_halt", o.halt, 1'b1);
        step(s_ack, o);
        chk1("to_halt_sticky", o.halt, 1'b1);
        chk1("to_halt_freeze", o.frz, 1'b1);
        chk1("to_halt_PCWrite", o.pc, 1'b0);
        do_reset(1);

        // Saturation: 2^CNT_W+5 consecutive load-use stalls.
        step(s_idle, o);
        step(s_idle, o);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            step(s_lu, o);
            if (i == CNT_MAX) chkn("sat_reach", o.cnt, CNT_W'(CNT_MAX));
        end
        step(s_idle, o);
        chkn("sat_hold", o.cnt, CNT_W'(CNT_MAX));

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            stim_t r;
            if ($urandom_range(0, 39) == 0) do_reset(1 + $urandom_range(0, 1));
            r.mr      = 1'($urandom_range(0, 1));
            r.idex_rt = 5'($urandom_range(0, 3));
            r.rs      = 5'($urandom_range(0, 3));
            r.rt      = 5'($urandom_range(0, 3));
            r.br      = ($urandom_range(0, 3) == 0);
            r.jmp     = ($urandom_range(0, 5) == 0);
            r.req     = ($urandom_range(0, 2) == 0);
            r.ack     = 1'($urandom_range(0, 1));
            step(r, o);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
